sysid_access_arbiter: RTL and testbench
=======================================

Name: sysid_access_arbiter

Overview:
- Sits between two Avalon-MM read masters (m0 = Nios II data master, m1 = JTAG/debug master) and the single combinational system-ID slave (1-bit address, 32-bit readdata; address 1 = ID word, address 0 = timestamp word).
- After reset, runs a two-read boot self-check of the ID and timestamp words against expected values, then arbitrates master reads round-robin.
- Every returned word is registered and delivered with fixed one-cycle latency.

Parameters:
- EXPECTED_ID, 32'h5242_2301, value the ID word (address 1) must return.
- EXPECTED_TS, 32'h0000_0000, value the timestamp word (address 0) must return.
- CHECK_EN, 1, 1 = run boot self-check; 0 = skip it, go straight to ARB with id_ok=1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_read  in  1  master 0 read request.
- m0_address  in  1  master 0 word address.
- m0_waitrequest  out  1  master 0 stall; low = read accepted this cycle.
- m0_readdata  out  32  master 0 read data.
- m0_readdatavalid  out  1  master 0 data strobe.
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: same as m0, for master 1.
- s_address  out  1  address to the sysid slave.
- s_readdata  in  32  sysid slave data (combinational from s_address).
- boot_done  out  1  self-check finished; arbitration enabled.
- id_ok  out  1  sticky: both boot reads matched.
- id_mismatch  out  1  sticky: at least one boot read mismatched.

Behaviour:
- Reset is asynchronous and active-high; clock and reset are the only clock/reset ports.
- Reset values: state=BOOT_ID (ARB if CHECK_EN=0); all readdatavalid=0; all readdata=0; boot_done=0 (1 if CHECK_EN=0); id_ok=0 (1 if CHECK_EN=0); id_mismatch=0; last_grant=1, so m0 wins the first tie.
- FSM states: BOOT_ID, BOOT_TS, ARB.
  - BOOT_ID: s_address=1; on the edge, mismatch flag set if s_readdata != EXPECTED_ID; go to BOOT_TS.
  - BOOT_TS: s_address=0; on the edge, mismatch flag updated if s_readdata != EXPECTED_TS; id_ok = no mismatch; id_mismatch = mismatch; boot_done=1; go to ARB.
  - ARB: terminal state until reset.
- Boot timing: boot_done rises on the 2nd rising edge after reset deasserts. id_ok and id_mismatch are mutually exclusive and never change afterwards.
- Both waitrequests are held high in BOOT_ID and BOOT_TS. Master reads issued during boot are stalled, not dropped.
- Grant (ARB state, combinational):
  - Only m0_read high: grant m0.
  - Only m1_read high: grant m1.
  - Both high: grant the master that is not last_grant.
  - Neither high: no grant; s_address=0; last_grant unchanged.
- mX_waitrequest = ~(state==ARB && grant==X). The non-granted requester sees waitrequest=1 and must hold its request.
- s_address = address of the granted master.
- Accepted read at edge T:
  - mX_readdata <= s_readdata and mX_readdatavalid=1 for exactly the cycle after T.
  - last_grant <= X.
  - Latency is exactly 1 cycle.
  - Throughput is 1 read per cycle in total; back-to-back reads from alternating masters are allowed.
- The non-granted master's readdatavalid is 0. Its readdata holds its last value.
- At most one readdatavalid is high per cycle.
- Reset asserted mid-operation: any pending readdatavalid is cleared immediately (async); the boot check reruns.

Decomposition:
- Shared package sysid_arb_pkg holds:
  - state enum (BOOT_ID, BOOT_TS, ARB);
  - address constants SYSID_ADDR_ID=1, SYSID_ADDR_TS=0.
- One natural sub-module, rr_arbiter2: a 2-requester round-robin grant with last_grant register and an update enable.
- FSM, boot compare and response registers stay in the top level.

Test Plan:
- Boot pass: slave returns 0x52422301 at address 1 and 0 at address 0 -> s_address is 1 then 0; boot_done=1 on the 2nd edge; id_ok=1; id_mismatch=0.
- Boot fail: slave returns 0x52422300 at address 1 -> id_mismatch=1, id_ok=0, boot_done=1. Arbitration still works afterwards.
- Single master: m0_read=1, m0_address=1 in ARB -> m0_waitrequest=0 that cycle; next cycle m0_readdatavalid=1 with m0_readdata=0x52422301; m1_readdatavalid=0.
- Contention: m0 and m1 both read continuously for 4 cycles -> grants alternate m0, m1, m0, m1; each readdatavalid pulses on alternate cycles; the waiting master sees waitrequest=1.
- Read during boot: m1_read=1 held from reset release -> m1_waitrequest=1 through BOOT_TS; read accepted in the first ARB cycle; data returned 1 cycle later.
- Reset mid-read: reset asserted in the cycle after acceptance -> readdatavalid drops to 0 asynchronously; after release boot_done=0 until the boot check reruns.

Source files
------------

// File: rtl/sysid_arb_pkg.sv
// Shared constants for the system-ID access arbiter: FSM encodings, slave word addresses, data width.
package sysid_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_BOOT_ID = 2'd0;
    localparam logic [STATE_W-1:0] ST_BOOT_TS = 2'd1;
    localparam logic [STATE_W-1:0] ST_ARB     = 2'd2;

    localparam logic SYSID_ADDR_ID = 1'b1;
    localparam logic SYSID_ADDR_TS = 1'b0;

endpackage

// File: rtl/sysid_access_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; the most recently served requester loses the next tie.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] grant_c
);

    logic last_grant_q;

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (update_en && (grant_c != 2'b00)) begin
            last_grant_q <= grant_c[1];
        end
    end

endmodule

// File: rtl/sysid_access_arbiter.sv
// Boot self-check of the sysid slave followed by round-robin sharing between two Avalon-MM read masters.
module sysid_access_arbiter
    import sysid_arb_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'h5242_2301,
    parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
    parameter bit          CHECK_EN    = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              s_address,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              boot_done,
    output logic              id_ok,
    output logic              id_mismatch
);

    localparam logic [STATE_W-1:0] RST_STATE = CHECK_EN ? ST_BOOT_ID : ST_ARB;
    localparam logic               RST_DONE  = CHECK_EN ? 1'b0 : 1'b1;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               in_arb_c;
    logic [1:0]         grant_c;
    logic               mismatch_q;
    logic               ts_bad_c;
    logic               boot_bad_c;

    assign in_arb_c   = (state_q == ST_ARB);
    assign ts_bad_c   = (s_readdata != EXPECTED_TS);
    assign boot_bad_c = mismatch_q | ts_bad_c;

    // Arbitration only advances once the boot check has handed over.
    rr_arbiter2 u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       ({m1_read & in_arb_c, m0_read & in_arb_c}),
        .update_en (in_arb_c),
        .grant_c   (grant_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational slave address and stall signals.
    always_comb begin
        state_d        = state_q;
        s_address      = SYSID_ADDR_TS;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            ST_BOOT_ID: begin
                s_address = SYSID_ADDR_ID;
                state_d   = ST_BOOT_TS;
            end
            ST_BOOT_TS: begin
                s_address = SYSID_ADDR_TS;
                state_d   = ST_ARB;
            end
            ST_ARB: begin
                m0_waitrequest = ~grant_c[0];
                m1_waitrequest = ~grant_c[1];
                if (grant_c[0]) begin
                    s_address = m0_address;
                end else if (grant_c[1]) begin
                    s_address = m1_address;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Boot compare; results are frozen once ARB is reached.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch_q  <= 1'b0;
            boot_done   <= RST_DONE;
            id_ok       <= RST_DONE;
            id_mismatch <= 1'b0;
        end else if (state_q == ST_BOOT_ID) begin
            mismatch_q <= (s_readdata != EXPECTED_ID);
        end else if (state_q == ST_BOOT_TS) begin
            mismatch_q  <= boot_bad_c;
            id_ok       <= ~boot_bad_c;
            id_mismatch <= boot_bad_c;
            boot_done   <= 1'b1;
        end
    end

    // One-cycle registered read response per master.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m0_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdata      <= '0;
            m1_readdatavalid <= 1'b0;
        end else begin
            m0_readdatavalid <= in_arb_c & grant_c[0];
            m1_readdatavalid <= in_arb_c & grant_c[1];
            if (in_arb_c && grant_c[0]) begin
                m0_readdata <= s_readdata;
            end
            if (in_arb_c && grant_c[1]) begin
                m1_readdata <= s_readdata;
            end
        end
    end

endmodule

// File: tb/tb_sysid_access_arbiter.sv
// Directed, table-driven bench for sysid_access_arbiter with a behavioural sysid slave.
module tb_sysid_access_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_read = 1'b0, m0_address = 1'b0;
    logic        m1_read = 1'b0, m1_address = 1'b0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_address;
    logic [31:0] s_readdata;
    logic        boot_done, id_ok, id_mismatch;

    logic [31:0] id_word = 32'h5242_2301;
    logic [31:0] ts_word = 32'h0000_0000;

    int n_cmp  = 0;
    int n_fail = 0;

    assign s_readdata = s_address ? id_word : ts_word;

    always #5 clock = ~clock;

    sysid_access_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .m0_read          (m0_read),
        .m0_address       (m0_address),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_address       (m1_address),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_readdata       (s_readdata),
        .boot_done        (boot_done),
        .id_ok            (id_ok),
        .id_mismatch      (id_mismatch)
    );

    typedef struct {
        logic        r0, a0, r1, a1;
        logic        w0, w1, sa;
        logic        v0, v1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_boot(input string tag, input logic done, input logic ok, input logic bad);
        chk({tag, " boot_done"}, 32'(boot_done), 32'(done));
        chk({tag, " id_ok"}, 32'(id_ok), 32'(ok));
        chk({tag, " id_mismatch"}, 32'(id_mismatch), 32'(bad));
    endtask

    initial begin
        // ts address returns a non-zero pattern during ARB so address routing is visible
        vecs[0] = '{1,1,0,0, 0,1,1, 1,0, 32'h5242_2301, 32'h0000_0000};
        vecs[1] = '{0,0,1,0, 1,0,0, 0,1, 32'h5242_2301, 32'hA5A5_0001};
        vecs[2] = '{1,1,1,1, 0,1,1, 1,0, 32'h5242_2301, 32'hA5A5_0001};
        vecs[3] = '{1,1,1,1, 1,0,1, 0,1, 32'h5242_2301, 32'h5242_2301};
        vecs[4] = '{1,0,1,1, 0,1,0, 1,0, 32'hA5A5_0001, 32'h5242_2301};
        vecs[5] = '{1,0,1,0, 1,0,0, 0,1, 32'hA5A5_0001, 32'hA5A5_0001};
        vecs[6] = '{0,1,0,1, 1,1,0, 0,0, 32'hA5A5_0001, 32'hA5A5_0001};
        vecs[7] = '{0,0,1,1, 1,0,1, 0,1, 32'hA5A5_0001, 32'h5242_2301};
        vecs[8] = '{1,1,1,0, 0,1,1, 1,0, 32'h5242_2301, 32'h5242_2301};

        // Boot pass
        repeat (2) @(negedge clock);
        chk("rst m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("rst m0_readdata", m0_readdata, 32'd0);
        chk_boot("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("boot_id s_address", 32'(s_address), 32'd1);
        chk("boot_id m0_wait", 32'(m0_waitrequest), 32'd1);
        @(posedge clock); #1;
        chk("boot_ts s_address", 32'(s_address), 32'd0);
        chk_boot("edge1", 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_boot("edge2", 1'b1, 1'b1, 1'b0);
        ts_word = 32'hA5A5_0001;

        // Table: single master, contention, idle, tie after same-master win
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            m0_read = vecs[i].r0; m0_address = vecs[i].a0;
            m1_read = vecs[i].r1; m1_address = vecs[i].a1;
            #1;
            chk($sformatf("v%0d m0_wait", i), 32'(m0_waitrequest), 32'(vecs[i].w0));
            chk($sformatf("v%0d m1_wait", i), 32'(m1_waitrequest), 32'(vecs[i].w1));
            chk($sformatf("v%0d s_address", i), 32'(s_address), 32'(vecs[i].sa));
            @(posedge clock); #1;
            chk($sformatf("v%0d m0_rdv", i), 32'(m0_readdatavalid), 32'(vecs[i].v0));
            chk($sformatf("v%0d m1_rdv", i), 32'(m1_readdatavalid), 32'(vecs[i].v1));
            chk($sformatf("v%0d m0_readdata", i), m0_readdata, vecs[i].d0);
            chk($sformatf("v%0d m1_readdata", i), m1_readdata, vecs[i].d1);
        end

        // Read held through boot
        @(negedge clock);
        m0_read = 1'b0; m1_read = 1'b1; m1_address = 1'b1; ts_word = 32'h0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("hold boot_id m1_wait", 32'(m1_waitrequest), 32'd1);
        @(posedge clock); #1;
        chk("hold boot_ts m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("hold boot_ts m1_rdv", 32'(m1_readdatavalid), 32'd0);
        @(posedge clock); #1;
        chk("hold arb m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("hold arb m1_rdv", 32'(m1_readdatavalid), 32'd0);
        @(posedge clock); #1;
        m1_read = 1'b0;
        chk("hold m1_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("hold m1_readdata", m1_readdata, 32'h5242_2301);

        // Reset one cycle after acceptance
        @(negedge clock);
        m0_read = 1'b1; m0_address = 1'b1;
        @(posedge clock); #1;
        m0_read = 1'b0;
        chk("midrst m0_rdv before", 32'(m0_readdatavalid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst m0_rdv async", 32'(m0_readdatavalid), 32'd0);
        chk("midrst m0_readdata", m0_readdata, 32'd0);
        chk_boot("midrst", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk_boot("midrst edge1", 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_boot("midrst edge2", 1'b1, 1'b1, 1'b0);

        // Boot fail, then arbitration still serves reads
        @(negedge clock);
        reset = 1'b1; id_word = 32'h5242_2300;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk_boot("fail edge1", 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_boot("fail edge2", 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        m0_read = 1'b1; m0_address = 1'b1;
        #1;
        chk("fail m0_wait", 32'(m0_waitrequest), 32'd0);
        @(posedge clock); #1;
        m0_read = 1'b0;
        chk("fail m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("fail m0_readdata", m0_readdata, 32'h5242_2300);
        repeat (3) @(posedge clock);
        #1;
        chk_boot("fail sticky", 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
